// File: rtl/disp_regbus_master_if.sv
// CPU-side AXI4-Lite signal bundle for the display register-bus bridge.
// master: the CPU interconnect; slave: the bridge.
interface disp_regbus_master_if;
   logic [31:0] S_AWADDR;
   logic        S_AWVALID;
   logic        S_AWREADY;
   logic [31:0] S_WDATA;
   logic [3:0]  S_WSTRB;
   logic        S_WVALID;
   logic        S_WREADY;
   logic [1:0]  S_BRESP;
   logic        S_BVALID;
   logic        S_BREADY;
   logic [31:0] S_ARADDR;
   logic        S_ARVALID;
   logic        S_ARREADY;
   logic [31:0] S_RDATA;
   logic [1:0]  S_RRESP;
   logic        S_RVALID;
   logic        S_RREADY;

   modport master (
      output S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
             S_ARADDR, S_ARVALID, S_RREADY,
      input  S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
             S_ARREADY, S_RDATA, S_RRESP, S_RVALID
   );

   modport slave (
      input  S_AWADDR, S_AWVALID, S_WDATA, S_WSTRB, S_WVALID, S_BREADY,
             S_ARADDR, S_ARVALID, S_RREADY,
      output S_AWREADY, S_WREADY, S_BRESP, S_BVALID,
             S_ARREADY, S_RDATA, S_RRESP, S_RVALID
   );
endinterface

// File: rtl/disp_regbus_master.sv
// AXI4-Lite slave to display register-bus initiator. One transaction in
// flight; each access becomes a single-cycle WREN or RDEN strobe.
// Optional build macro REGBUS_SLVERR_EN: addresses with bits [31:16] set
// are not strobed and are answered with SLVERR (reads return zero).
module disp_regbus_master #(
   parameter int RD_LAT = 1          // RDEN cycle to RDATA-valid cycle, 1..4
) (
   input  logic                      ACLK,
   input  logic                      ARST,
   disp_regbus_master_if.slave       axi,
   output logic [15:0]               WRADDR,
   output logic [3:0]                BYTEEN,
   output logic                      WREN,
   output logic [31:0]               WDATA,
   output logic [15:0]               RDADDR,
   output logic                      RDEN,
   input  logic [31:0]               RDATA
);

   typedef enum logic [2:0] {IDLE, WSTB, BRSP, RSTB, RWAIT, RRSP} state_t;

   state_t      state_q, state_d;
   logic        pri_wr_q, pri_wr_d;     // 1: write wins a simultaneous request
   logic        err_q, err_d;           // current access is out of range
   logic [1:0]  lat_cnt_q, lat_cnt_d;
   logic [15:0] wraddr_q, wraddr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  byteen_q, byteen_d;
   logic [15:0] rdaddr_q, rdaddr_d;
   logic [31:0] rdata_q, rdata_d;

   logic        wr_req, rd_req;
   logic        wr_grant, rd_grant;
   logic        aw_err, ar_err;

   assign wr_req = axi.S_AWVALID & axi.S_WVALID;
   assign rd_req = axi.S_ARVALID;

`ifdef REGBUS_SLVERR_EN
   logic unused_addr_bits;
   assign aw_err = |axi.S_AWADDR[31:16];
   assign ar_err = |axi.S_ARADDR[31:16];
   assign unused_addr_bits = ^{axi.S_AWADDR[1:0], axi.S_ARADDR[1:0]};
`else
   logic unused_addr_bits;
   assign aw_err = 1'b0;
   assign ar_err = 1'b0;
   assign unused_addr_bits = ^{axi.S_AWADDR[31:16], axi.S_AWADDR[1:0],
                               axi.S_ARADDR[31:16], axi.S_ARADDR[1:0]};
`endif

   // Next-state, arbitration and register-bus latch values.
   always_comb begin
      state_d   = state_q;
      pri_wr_d  = pri_wr_q;
      err_d     = err_q;
      lat_cnt_d = lat_cnt_q;
      wraddr_d  = wraddr_q;
      wdata_d   = wdata_q;
      byteen_d  = byteen_q;
      rdaddr_d  = rdaddr_q;
      rdata_d   = rdata_q;
      wr_grant  = 1'b0;
      rd_grant  = 1'b0;

      case (state_q)
         IDLE: begin
            // The type granted last loses a tie; a lone request always wins.
            if (wr_req && (pri_wr_q || !rd_req)) begin
               wr_grant = 1'b1;
               wraddr_d = {axi.S_AWADDR[15:2], 2'b00};
               wdata_d  = axi.S_WDATA;
               byteen_d = axi.S_WSTRB;
               err_d    = aw_err;
               pri_wr_d = 1'b0;
               state_d  = WSTB;
            end else if (rd_req) begin
               rd_grant = 1'b1;
               rdaddr_d = {axi.S_ARADDR[15:2], 2'b00};
               err_d    = ar_err;
               pri_wr_d = 1'b1;
               state_d  = RSTB;
            end
         end
         WSTB: state_d = BRSP;
         BRSP: if (axi.S_BREADY) state_d = IDLE;
         RSTB: begin
            lat_cnt_d = 2'(RD_LAT - 1);
            state_d   = RWAIT;
         end
         // The last RWAIT cycle is the one in which RDATA is valid.
         RWAIT: begin
            if (lat_cnt_q == 2'd0) begin
               rdata_d = err_q ? 32'h0 : RDATA;
               state_d = RRSP;
            end else begin
               lat_cnt_d = lat_cnt_q - 2'd1;
            end
         end
         RRSP: if (axi.S_RREADY) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and latched bus values; reset clears every output source.
   always_ff @(posedge ACLK) begin
      if (ARST) begin
         state_q   <= IDLE;
         pri_wr_q  <= 1'b1;
         err_q     <= 1'b0;
         lat_cnt_q <= 2'd0;
         wraddr_q  <= 16'h0;
         wdata_q   <= 32'h0;
         byteen_q  <= 4'h0;
         rdaddr_q  <= 16'h0;
         rdata_q   <= 32'h0;
      end else begin
         state_q   <= state_d;
         pri_wr_q  <= pri_wr_d;
         err_q     <= err_d;
         lat_cnt_q <= lat_cnt_d;
         wraddr_q  <= wraddr_d;
         wdata_q   <= wdata_d;
         byteen_q  <= byteen_d;
         rdaddr_q  <= rdaddr_d;
         rdata_q   <= rdata_d;
      end
   end

   // Ready is withheld during reset so no handshake is silently lost.
   assign axi.S_AWREADY = wr_grant & ~ARST;
   assign axi.S_WREADY  = wr_grant & ~ARST;
   assign axi.S_ARREADY = rd_grant & ~ARST;

   assign axi.S_BVALID  = (state_q == BRSP);
   assign axi.S_BRESP   = {(state_q == BRSP) & err_q, 1'b0};
   assign axi.S_RVALID  = (state_q == RRSP);
   assign axi.S_RRESP   = {(state_q == RRSP) & err_q, 1'b0};
   assign axi.S_RDATA   = rdata_q;

   assign WREN   = (state_q == WSTB) & ~err_q;
   assign RDEN   = (state_q == RSTB) & ~err_q;
   assign WRADDR = wraddr_q;
   assign WDATA  = wdata_q;
   assign BYTEEN = byteen_q;
   assign RDADDR = rdaddr_q;

endmodule

// File: tb/tb_disp_regbus_master.sv
// Scoreboard bench for disp_regbus_master: stimulus tasks push expected
// strobes/responses; a negedge monitor pops and compares them and runs a
// transaction-level arbitration model for the ready signals.
module tb_disp_regbus_master;
   localparam int RD_LAT = 3;
`ifdef REGBUS_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   logic        ACLK;
   logic        ARST;
   logic [15:0] WRADDR, RDADDR;
   logic [3:0]  BYTEEN;
   logic        WREN, RDEN;
   logic [31:0] WDATA, RDATA;

   disp_regbus_master_if bus();

   disp_regbus_master #(.RD_LAT(RD_LAT)) dut (
      .ACLK(ACLK), .ARST(ARST), .axi(bus.slave),
      .WRADDR(WRADDR), .BYTEEN(BYTEEN), .WREN(WREN), .WDATA(WDATA),
      .RDADDR(RDADDR), .RDEN(RDEN), .RDATA(RDATA)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   bit mon_en = 1'b0;

   always @(posedge ACLK) cyc <= cyc + 1;

   typedef struct { logic [15:0] addr; logic [31:0] data; logic [3:0] be; } wstb_t;
   typedef struct { logic [31:0] data; logic [1:0] resp; } rsp_t;
   wstb_t       wstb_q[$];
   logic [15:0] rstb_q[$];
   logic [1:0]  b_q[$];
   rsp_t        r_q[$];
   byte         grant_log[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- reference model helpers ----------------
   function automatic bit is_err(input logic [31:0] a);
      return SLVERR_EN && (a[31:16] != 16'h0);
   endfunction

   function automatic logic [31:0] rd_val(input logic [15:0] a);
      return 32'hA5A5_0001 + 32'(16'(a - 16'h0008)) * 32'h0001_0003;
   endfunction

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 3) != 0) a[31:16] = 16'h0;
      return a;
   endfunction

   // ---------------- register-bus read responder ----------------
   logic        rd_pipe [0:3];
   logic [15:0] ad_pipe [0:3];
   initial for (int i = 0; i < 4; i++) begin rd_pipe[i] = 1'b0; ad_pipe[i] = 16'h0; end

   always @(posedge ACLK) begin
      rd_pipe[0] <= (RDEN === 1'b1);
      ad_pipe[0] <= RDADDR;
      for (int i = 1; i < 4; i++) begin
         rd_pipe[i] <= rd_pipe[i-1];
         ad_pipe[i] <= ad_pipe[i-1];
      end
   end

   // RDATA is only meaningful RD_LAT cycles after RDEN; junk elsewhere.
   always_comb begin
      RDATA = 32'hDEAD_0000 | 32'(cyc[15:0]);
      if (rd_pipe[RD_LAT-1]) RDATA = rd_val(ad_pipe[RD_LAT-1]);
   end

   // ---------------- monitor / scoreboard ----------------
   bit m_free = 1'b1, m_pri_wr = 1'b1;
   int aw_hs = -100, ar_hs = -100;
   bit b_on = 1'b0, r_on = 1'b0, prev_b_wait = 1'b0, prev_r_wait = 1'b0;

   always @(negedge ACLK) begin
      if (mon_en) begin
         automatic bit wreq = bus.S_AWVALID && bus.S_WVALID;
         automatic bit rreq = bus.S_ARVALID;
         automatic bit exp_w = m_free && !ARST && wreq && (m_pri_wr || !rreq);
         automatic bit exp_r = m_free && !ARST && rreq && !exp_w;
         if (wreq || rreq || bus.S_AWVALID || bus.S_WVALID ||
             bus.S_AWREADY || bus.S_WREADY || bus.S_ARREADY) begin
            check("awready", 32'(bus.S_AWREADY), 32'(exp_w));
            check("wready",  32'(bus.S_WREADY),  32'(exp_w));
            check("arready", 32'(bus.S_ARREADY), 32'(exp_r));
         end
         if (bus.S_AWREADY === 1'b1 && wreq) grant_log.push_back("W");
         if (bus.S_ARREADY === 1'b1 && rreq) grant_log.push_back("R");
         if (exp_w) begin m_free = 1'b0; m_pri_wr = 1'b0; aw_hs = cyc; end
         else if (exp_r) begin m_free = 1'b0; m_pri_wr = 1'b1; ar_hs = cyc; end

         if (WREN === 1'b1 || RDEN === 1'b1)
            check("wren_rden_exclusive", 32'(WREN && RDEN), 32'd0);

         if (WREN === 1'b1) begin
            if (wstb_q.size() == 0) check("wren_unexpected", 32'd1, 32'd0);
            else begin
               automatic wstb_t e = wstb_q.pop_front();
               check("wraddr", 32'(WRADDR), 32'(e.addr));
               check("wdata", WDATA, e.data);
               check("byteen", 32'(BYTEEN), 32'(e.be));
               check("wren_cycle", 32'(cyc), 32'(aw_hs + 1));
            end
         end
         if (RDEN === 1'b1) begin
            if (rstb_q.size() == 0) check("rden_unexpected", 32'd1, 32'd0);
            else begin
               automatic logic [15:0] ea = rstb_q.pop_front();
               check("rdaddr", 32'(RDADDR), 32'(ea));
               check("rden_cycle", 32'(cyc), 32'(ar_hs + 1));
            end
         end

         if (prev_b_wait) check("bvalid_hold", 32'(bus.S_BVALID), 32'd1);
         if (bus.S_BVALID === 1'b1 && !b_on) begin
            b_on = 1'b1;
            check("bvalid_latency", 32'(cyc), 32'(aw_hs + 2));
         end
         if (bus.S_BVALID === 1'b1 && bus.S_BREADY) begin
            if (b_q.size() == 0) check("bresp_unexpected", 32'd1, 32'd0);
            else check("bresp", 32'(bus.S_BRESP), 32'(b_q.pop_front()));
            b_on = 1'b0;
            m_free = 1'b1;
         end
         prev_b_wait = (bus.S_BVALID === 1'b1) && !bus.S_BREADY;

         if (prev_r_wait) check("rvalid_hold", 32'(bus.S_RVALID), 32'd1);
         if (bus.S_RVALID === 1'b1 && !r_on) begin
            r_on = 1'b1;
            check("rvalid_latency", 32'(cyc), 32'(ar_hs + 2 + RD_LAT));
         end
         if (bus.S_RVALID === 1'b1) begin
            if (r_q.size() == 0) check("rvalid_unexpected", 32'd1, 32'd0);
            else if (bus.S_RREADY) begin
               automatic rsp_t e = r_q.pop_front();
               check("rdata", bus.S_RDATA, e.data);
               check("rresp", 32'(bus.S_RRESP), 32'(e.resp));
               r_on = 1'b0;
               m_free = 1'b1;
            end else begin
               check("rdata_stable", bus.S_RDATA, r_q[0].data);
            end
         end
         prev_r_wait = (bus.S_RVALID === 1'b1) && !bus.S_RREADY;

         if (ARST) begin
            m_free = 1'b1; m_pri_wr = 1'b1;
            b_on = 1'b0; r_on = 1'b0; prev_b_wait = 1'b0; prev_r_wait = 1'b0;
         end
      end
   end

   // ---------------- stimulus tasks ----------------
   task automatic do_write(input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int wdelay, input int bstall);
      bit hs = 1'b0;
      bit done = 1'b0;
      wstb_t e;
      if (!is_err(addr)) begin
         e.addr = {addr[15:2], 2'b00}; e.data = data; e.be = strb;
         wstb_q.push_back(e);
      end
      b_q.push_back(is_err(addr) ? 2'b10 : 2'b00);
      @(posedge ACLK); #1;
      bus.S_AWADDR = addr; bus.S_AWVALID = 1'b1;
      bus.S_WDATA = data; bus.S_WSTRB = strb; bus.S_WVALID = (wdelay == 0);
      for (int k = 0; k < 300; k++) begin
         @(negedge ACLK);
         if (bus.S_AWVALID && bus.S_WVALID && bus.S_AWREADY === 1'b1) begin hs = 1'b1; break; end
         @(posedge ACLK); #1;
         if (k + 1 >= wdelay) bus.S_WVALID = 1'b1;
      end
      if (!hs) check("aw_handshake_timeout", 32'd0, 32'd1);
      @(posedge ACLK); #1;
      bus.S_AWVALID = 1'b0; bus.S_WVALID = 1'b0;
      bus.S_WDATA = $urandom; bus.S_AWADDR = $urandom;
      if (!hs) return;
      bus.S_BREADY = (bstall == 0);
      if (bstall > 0) begin
         for (int k = 0; k < 300; k++) begin
            @(negedge ACLK);
            if (bus.S_BVALID === 1'b1) break;
         end
         repeat (bstall) @(posedge ACLK);
         #1 bus.S_BREADY = 1'b1;
      end
      for (int k = 0; k < 300; k++) begin
         @(negedge ACLK);
         if (bus.S_BVALID === 1'b1 && bus.S_BREADY) begin done = 1'b1; break; end
      end
      if (!done) check("b_handshake_timeout", 32'd0, 32'd1);
      @(posedge ACLK); #1 bus.S_BREADY = 1'b0;
   endtask

   task automatic do_read(input logic [31:0] addr, input int rstall);
      bit hs = 1'b0;
      bit done = 1'b0;
      rsp_t e;
      if (!is_err(addr)) rstb_q.push_back({addr[15:2], 2'b00});
      e.data = is_err(addr) ? 32'h0 : rd_val({addr[15:2], 2'b00});
      e.resp = is_err(addr) ? 2'b10 : 2'b00;
      r_q.push_back(e);
      @(posedge ACLK); #1;
      bus.S_ARADDR = addr; bus.S_ARVALID = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge ACLK);
         if (bus.S_ARREADY === 1'b1) begin hs = 1'b1; break; end
      end
      if (!hs) check("ar_handshake_timeout", 32'd0, 32'd1);
      @(posedge ACLK); #1;
      bus.S_ARVALID = 1'b0; bus.S_ARADDR = $urandom;
      if (!hs) return;
      bus.S_RREADY = (rstall == 0);
      if (rstall > 0) begin
         for (int k = 0; k < 300; k++) begin
            @(negedge ACLK);
            if (bus.S_RVALID === 1'b1) break;
         end
         repeat (rstall) @(posedge ACLK);
         #1 bus.S_RREADY = 1'b1;
      end
      for (int k = 0; k < 300; k++) begin
         @(negedge ACLK);
         if (bus.S_RVALID === 1'b1 && bus.S_RREADY) begin done = 1'b1; break; end
      end
      if (!done) check("r_handshake_timeout", 32'd0, 32'd1);
      @(posedge ACLK); #1 bus.S_RREADY = 1'b0;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      bit hs;
      ARST = 1'b1;
      bus.S_AWADDR = '0; bus.S_AWVALID = 1'b0; bus.S_WDATA = '0; bus.S_WSTRB = '0;
      bus.S_WVALID = 1'b0; bus.S_BREADY = 1'b0; bus.S_ARADDR = '0;
      bus.S_ARVALID = 1'b0; bus.S_RREADY = 1'b0;
      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check("rst_awready", 32'(bus.S_AWREADY), 32'd0);
      check("rst_wready", 32'(bus.S_WREADY), 32'd0);
      check("rst_arready", 32'(bus.S_ARREADY), 32'd0);
      check("rst_bvalid", 32'(bus.S_BVALID), 32'd0);
      check("rst_bresp", 32'(bus.S_BRESP), 32'd0);
      check("rst_rvalid", 32'(bus.S_RVALID), 32'd0);
      check("rst_rresp", 32'(bus.S_RRESP), 32'd0);
      check("rst_rdata", bus.S_RDATA, 32'd0);
      check("rst_wren", 32'(WREN), 32'd0);
      check("rst_rden", 32'(RDEN), 32'd0);
      check("rst_wraddr", 32'(WRADDR), 32'd0);
      check("rst_wdata", WDATA, 32'd0);
      check("rst_byteen", 32'(BYTEEN), 32'd0);
      check("rst_rdaddr", 32'(RDADDR), 32'd0);
      @(posedge ACLK); #1 ARST = 1'b0;
      mon_en = 1'b1;

      do_write(32'h0000_0004, 32'h0000_0001, 4'hF, 0, 0);
      do_read(32'h0000_0008, 0);

      // Two simultaneous write+read pairs must interleave W,R,W,R.
      grant_log.delete();
      repeat (2) fork
         do_write(rand_addr() & 32'h0000_FFFF, $urandom, 4'($urandom), 0, 0);
         do_read(rand_addr() & 32'h0000_FFFF, 0);
      join
      check("order_len", 32'(grant_log.size()), 32'd4);
      if (grant_log.size() == 4) begin
         check("order_0", 32'(grant_log[0]), 32'("W"));
         check("order_1", 32'(grant_log[1]), 32'("R"));
         check("order_2", 32'(grant_log[2]), 32'("W"));
         check("order_3", 32'(grant_log[3]), 32'("R"));
      end

      do_write(32'h0000_1230, 32'hCAFE_F00D, 4'h5, 0, 5);
      do_read(32'h0000_0ABC, 4);

      // Reset during the RDEN cycle discards the read.
      rstb_q.push_back(16'h0010);
      hs = 1'b0;
      @(posedge ACLK); #1;
      bus.S_ARADDR = 32'h0000_0010; bus.S_ARVALID = 1'b1;
      for (int k = 0; k < 300; k++) begin
         @(negedge ACLK);
         if (bus.S_ARREADY === 1'b1) begin hs = 1'b1; break; end
      end
      check("rst_test_handshake", 32'(hs), 32'd1);
      @(posedge ACLK); #1;
      bus.S_ARVALID = 1'b0; ARST = 1'b1;
      @(posedge ACLK); #1 ARST = 1'b0;
      repeat (RD_LAT + 4) begin
         @(negedge ACLK);
         check("rst_mid_rden_low", 32'(RDEN), 32'd0);
         check("rst_mid_rvalid_low", 32'(bus.S_RVALID), 32'd0);
      end
      do_read(32'h0000_0010, 0);

      do_write(32'h0001_0000, 32'h1234_5678, 4'hF, 0, 0);
      do_read(32'h0002_0000, 0);

      for (int it = 0; it < 150; it++) begin
         case ($urandom_range(0, 3))
            0: do_write(rand_addr(), $urandom, 4'($urandom), 0, $urandom_range(0, 3));
            1: do_read(rand_addr(), $urandom_range(0, 3));
            2: fork
                  do_write(rand_addr(), $urandom, 4'($urandom), 0, $urandom_range(0, 2));
                  do_read(rand_addr(), $urandom_range(0, 2));
               join
            default: fork
                  do_write(rand_addr(), $urandom, 4'($urandom), $urandom_range(1, 3), $urandom_range(0, 2));
                  do_read(rand_addr(), $urandom_range(0, 2));
               join
         endcase
         repeat ($urandom_range(0, 2)) @(posedge ACLK);
      end

      repeat (10) @(posedge ACLK);
      check("wstb_queue_drained", 32'(wstb_q.size()), 32'd0);
      check("rstb_queue_drained", 32'(rstb_q.size()), 32'd0);
      check("b_queue_drained", 32'(b_q.size()), 32'd0);
      check("r_queue_drained", 32'(r_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got %0d cycles, expected completion", cyc);
      $fatal(1, "watchdog");
   end

endmodule
